dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters: the core load/store path
//  (port C, driven by the decoder's memory signals) and a program loader/debug DMA
//  (port D). Sequences each access and absorbs the one-cycle memory read latency.

---
 rtl/dmem_arbiter_pkg.sv | 13 +
 rtl/dmem_arbiter_if.sv | 17 +
 rtl/dmem_arbiter_rr.sv | 40 ++++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  // Requester ids double as bit positions in the req/gnt vectors.
  localparam logic REQ_C = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's access port: request fields in, accept/read-return strobes out.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              stall;

  modport master (output req, we, addr, wdata, input ack, rvalid, rdata, stall);
  modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata, stall);
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way arbiter: single requester always wins; on contention either the core
// wins outright (fixed priority) or the pointer side wins and the pointer moves
// to the loser.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_fixed_prio,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  logic r_ptr;
  logic w_contended;

  assign w_contended = &i_req;

  // Grant selection from request vector and tie-break pointer.
  always_comb begin
    o_gnt = '0;
    unique case (i_req)
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: o_gnt = (i_fixed_prio || r_ptr == REQ_C) ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

  // Pointer moves to the losing side only after a contended grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= REQ_C;
    end else if (i_advance && w_contended && !i_fixed_prio) begin
      r_ptr <= o_gnt[REQ_C] ? REQ_D : REQ_C;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (C) and the loader/DMA (D).
// Accepts one access per idle cycle; a read holds off all grants for the one
// cycle in which the memory returns data.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     c_bus,
  dmem_arbiter_if.slave     d_bus,
  output logic              o_mem_we,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_grant_en;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  // Requests are only visible to the arbiter when a grant is possible, so
  // the pointer never moves in RD_WAIT or under reset.
  assign w_grant_en = (r_state == IDLE) && !rst;
  assign w_req      = w_grant_en ? {d_bus.req, c_bus.req} : 2'b00;

  rr_arbiter2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .i_req        (w_req),
    .i_fixed_prio (FIXED_PRIO != 0),
    .i_advance    (w_grant_en),
    .o_gnt        (w_gnt)
  );

  assign w_win_we    = w_gnt[REQ_D] ? d_bus.we    : c_bus.we;
  assign w_win_addr  = w_gnt[REQ_D] ? d_bus.addr  : c_bus.addr;
  assign w_win_wdata = w_gnt[REQ_D] ? d_bus.wdata : c_bus.wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: a granted read waits one cycle for memory data.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (|w_gnt && !w_win_we) w_next_state = RD_WAIT;
      RD_WAIT: w_next_state = IDLE;
    endcase
  end

  // Read owner and per-port held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= REQ_C;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (r_state == IDLE && |w_gnt) begin
        r_owner <= w_gnt[REQ_D] ? REQ_D : REQ_C;
      end
      if (r_state == RD_WAIT) begin
        if (r_owner == REQ_C) begin
          r_c_rdata <= i_mem_rdata;
        end else begin
          r_d_rdata <= i_mem_rdata;
        end
      end
    end
  end

  // Outputs: memory mux and acks in IDLE, owner's read return in RD_WAIT.
  // The owner sees i_mem_rdata directly during RD_WAIT; the register only
  // supplies the held value afterwards, so rvalid lands one cycle after ack.
  always_comb begin
    o_mem_we     = 1'b0;
    o_mem_re     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    c_bus.ack    = 1'b0;
    d_bus.ack    = 1'b0;
    c_bus.rvalid = 1'b0;
    d_bus.rvalid = 1'b0;
    c_bus.rdata  = r_c_rdata;
    d_bus.rdata  = r_d_rdata;
    c_bus.stall  = 1'b0;
    d_bus.stall  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            o_mem_we    = w_win_we;
            o_mem_re    = !w_win_we;
            o_mem_addr  = w_win_addr;
            o_mem_wdata = w_win_wdata;
            c_bus.ack   = w_gnt[REQ_C];
            d_bus.ack   = w_gnt[REQ_D];
          end
        end
        RD_WAIT: begin
          if (r_owner == REQ_C) begin
            c_bus.rvalid = 1'b1;
            c_bus.rdata  = i_mem_rdata;
          end else begin
            d_bus.rvalid = 1'b1;
            d_bus.rdata  = i_mem_rdata;
          end
        end
      endcase
      c_bus.stall = (c_bus.req && !c_bus.ack) || (r_state == RD_WAIT && r_owner == REQ_C);
      d_bus.stall = (d_bus.req && !d_bus.ack) || (r_state == RD_WAIT && r_owner == REQ_D);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: DUT 0 is round-robin, DUT 1 fixed-priority. Each has
// its own memory, directed scenarios with literal expectations, then random
// traffic against a transaction-level model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // [dut][port], port 0 = C, 1 = D
  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic        ack   [2][2];
  logic        rvalid[2][2];
  logic        stall [2][2];
  logic [31:0] rdata [2][2];

  logic        mem_we   [2];
  logic        mem_re   [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2] = '{default: '0};
  logic [31:0] xmem[2][16]  = '{default: '{default: '0}};

  dmem_arbiter_if c0 (), d0 (), c1 (), d1 ();

  assign c0.req = req[0][0]; assign c0.we = we[0][0]; assign c0.addr = addr[0][0]; assign c0.wdata = wdata[0][0];
  assign d0.req = req[0][1]; assign d0.we = we[0][1]; assign d0.addr = addr[0][1]; assign d0.wdata = wdata[0][1];
  assign c1.req = req[1][0]; assign c1.we = we[1][0]; assign c1.addr = addr[1][0]; assign c1.wdata = wdata[1][0];
  assign d1.req = req[1][1]; assign d1.we = we[1][1]; assign d1.addr = addr[1][1]; assign d1.wdata = wdata[1][1];
  assign ack[0][0] = c0.ack; assign rvalid[0][0] = c0.rvalid; assign rdata[0][0] = c0.rdata; assign stall[0][0] = c0.stall;
  assign ack[0][1] = d0.ack; assign rvalid[0][1] = d0.rvalid; assign rdata[0][1] = d0.rdata; assign stall[0][1] = d0.stall;
  assign ack[1][0] = c1.ack; assign rvalid[1][0] = c1.rvalid; assign rdata[1][0] = c1.rdata; assign stall[1][0] = c1.stall;
  assign ack[1][1] = d1.ack; assign rvalid[1][1] = d1.rvalid; assign rdata[1][1] = d1.rdata; assign stall[1][1] = d1.stall;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .c_bus(c0), .d_bus(d0),
    .o_mem_we(mem_we[0]), .o_mem_re(mem_re[0]), .o_mem_addr(mem_addr[0]),
    .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst), .c_bus(c1), .d_bus(d1),
    .o_mem_we(mem_we[1]), .o_mem_re(mem_re[1]), .o_mem_addr(mem_addr[1]),
    .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1])
  );

  // 16-word memories with one-cycle read latency.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (mem_we[p]) xmem[p][mem_addr[p][5:2]] <= mem_wdata[p];
      if (mem_re[p]) mem_rdata[p] <= xmem[p][mem_addr[p][5:2]];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(string name, int p, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, p, $time, act, exp);
    end
  endfunction

  // Model state: pending read owner (-1 = none) and its data, tie pointer,
  // shadow memory contents, and last data returned to each port.
  int          pend     [2] = '{-1, -1};
  int          ptr      [2] = '{0, 0};
  logic [31:0] pend_data[2];
  logic [31:0] mdl_mem  [2][16] = '{default: '{default: '0}};
  logic [31:0] last_rd  [2][2]  = '{default: '{default: '0}};
  logic        seen_ack [2][2]  = '{default: '{default: 1'b0}};

  int          m_w;
  logic        m_ack[2], m_rv[2], m_st[2];
  logic        m_we, m_re;
  logic [31:0] m_addr, m_wd;
  logic [31:0] m_rd[2];

  // Compare every DUT output against the model each cycle, then step the model
  // through the coming rising edge.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      m_w = -1; m_we = 1'b0; m_re = 1'b0; m_addr = '0; m_wd = '0;
      for (int q = 0; q < 2; q++) begin
        m_ack[q] = 1'b0; m_rv[q] = 1'b0; m_st[q] = 1'b0; m_rd[q] = last_rd[p][q];
      end
      if (!rst) begin
        if (pend[p] >= 0) begin
          m_rv[pend[p]] = 1'b1;
          m_rd[pend[p]] = pend_data[p];
        end else begin
          if (req[p][0] && req[p][1]) m_w = (p == 1) ? 0 : ptr[p];
          else if (req[p][0])         m_w = 0;
          else if (req[p][1])         m_w = 1;
          if (m_w >= 0) begin
            m_ack[m_w] = 1'b1;
            m_we   = we[p][m_w];
            m_re   = !we[p][m_w];
            m_addr = addr[p][m_w];
            m_wd   = wdata[p][m_w];
          end
        end
        for (int q = 0; q < 2; q++) m_st[q] = (req[p][q] && !m_ack[q]) || (pend[p] == q);
      end
      for (int q = 0; q < 2; q++) begin
        chk(q == 0 ? "c_ack"    : "d_ack",    p, 32'(ack[p][q]),    32'(m_ack[q]));
        chk(q == 0 ? "c_rvalid" : "d_rvalid", p, 32'(rvalid[p][q]), 32'(m_rv[q]));
        chk(q == 0 ? "c_stall"  : "d_stall",  p, 32'(stall[p][q]),  32'(m_st[q]));
        if (!rst) chk(q == 0 ? "c_rdata" : "d_rdata", p, rdata[p][q], m_rd[q]);
        seen_ack[p][q] = ack[p][q];
      end
      chk("mem_we",    p, 32'(mem_we[p]), 32'(m_we));
      chk("mem_re",    p, 32'(mem_re[p]), 32'(m_re));
      chk("mem_addr",  p, mem_addr[p],    m_addr);
      chk("mem_wdata", p, mem_wdata[p],   m_wd);

      if (rst) begin
        pend[p] = -1;
        ptr[p]  = 0;
        last_rd[p][0] = '0;
        last_rd[p][1] = '0;
      end else if (pend[p] >= 0) begin
        last_rd[p][pend[p]] = pend_data[p];
        pend[p] = -1;
      end else if (m_w >= 0) begin
        if (we[p][m_w]) begin
          mdl_mem[p][addr[p][m_w][5:2]] = wdata[p][m_w];
        end else begin
          pend[p]      = m_w;
          pend_data[p] = mdl_mem[p][addr[p][m_w][5:2]];
        end
        if (req[p][0] && req[p][1] && p == 0) ptr[p] = 1 - m_w;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input int q, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    req[p][q]   = r;
    we[p][q]    = w;
    addr[p][q]  = a;
    wdata[p][q] = d;
  endtask

  initial begin
    for (int p = 0; p < 2; p++)
      for (int q = 0; q < 2; q++) drive(p, q, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_c_ack",  0, 32'(ack[0][0]),  0);
    chk("rst_mem_we", 0, 32'(mem_we[0]),  0);
    chk("rst_mem_re", 0, 32'(mem_re[0]),  0);
    chk("rst_addr",   0, mem_addr[0],     0);
    chk("rst_rdata",  0, rdata[0][0],     0);
    chk("rst_stall",  0, 32'(stall[0][0]), 0);

    // Core write accepted same cycle
    tick(); drive(0, 0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_c_ack",  0, 32'(ack[0][0]), 1);
    chk("t1_mem_we", 0, 32'(mem_we[0]), 1);
    chk("t1_addr",   0, mem_addr[0],    32'h10);
    chk("t1_wdata",  0, mem_wdata[0],   32'hDEADBEEF);

    // Core read: ack, then rvalid with data, then stall clear and data held
    tick(); drive(0, 0, 1'b1, 1'b0, 32'h10, '0);
    @(negedge clk);
    chk("t2_c_ack",  0, 32'(ack[0][0]), 1);
    chk("t2_mem_re", 0, 32'(mem_re[0]), 1);
    tick(); drive(0, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t2_rvalid", 0, 32'(rvalid[0][0]), 1);
    chk("t2_rdata",  0, rdata[0][0],       32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("t2_stall",     0, 32'(stall[0][0]),  0);
    chk("t2_rvalid_lo", 0, 32'(rvalid[0][0]), 0);
    chk("t2_rdata_hold", 0, rdata[0][0],      32'hDEADBEEF);

    // Contended writes alternate C,D,C,D
    tick();
    drive(0, 0, 1'b1, 1'b1, 32'h20, 32'hC0C0C0C0);
    drive(0, 1, 1'b1, 1'b1, 32'h24, 32'hD0D0D0D0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_c_ack", 0, 32'(ack[0][0]), 32'(i % 2 == 0));
      chk("t3_d_ack", 0, 32'(ack[0][1]), 32'(i % 2 == 1));
      tick();
    end

    // D read blocks C for the return cycle
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b1, 1'b0, 32'h24, '0);
    @(negedge clk);
    chk("t4_d_ack", 0, 32'(ack[0][1]), 1);
    tick();
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    drive(0, 0, 1'b1, 1'b1, 32'h30, 32'h12345678);
    @(negedge clk);
    chk("t4_c_ack_wait", 0, 32'(ack[0][0]),    0);
    chk("t4_c_stall",    0, 32'(stall[0][0]),  1);
    chk("t4_d_rvalid",   0, 32'(rvalid[0][1]), 1);
    chk("t4_d_rdata",    0, rdata[0][1],       32'hD0D0D0D0);
    tick();
    @(negedge clk);
    chk("t4_c_ack", 0, 32'(ack[0][0]), 1);
    tick(); drive(0, 0, 1'b0, 1'b0, '0, '0);

    // Move pointer to D, then reset during a D read
    drive(0, 0, 1'b1, 1'b1, 32'h34, 32'h1);
    drive(0, 1, 1'b1, 1'b1, 32'h38, 32'h2);
    @(negedge clk);
    chk("t5_pre_c_ack", 0, 32'(ack[0][0]), 1);
    tick();
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    tick(); drive(0, 1, 1'b1, 1'b0, 32'h24, '0);
    @(negedge clk);
    chk("t5_d_ack", 0, 32'(ack[0][1]), 1);
    tick(); rst = 1'b1; drive(0, 1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t5_d_rvalid_rst", 0, 32'(rvalid[0][1]), 0);
    tick(); rst = 1'b0;
    drive(0, 0, 1'b1, 1'b1, 32'h08, 32'h3);
    drive(0, 1, 1'b1, 1'b1, 32'h0C, 32'h4);
    @(negedge clk);
    chk("t5_c_ack",    0, 32'(ack[0][0]),    1);
    chk("t5_d_ack",    0, 32'(ack[0][1]),    0);
    chk("t5_d_rvalid", 0, 32'(rvalid[0][1]), 0);
    tick();
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);

    // Fixed priority: C always wins until it drops
    drive(1, 0, 1'b1, 1'b1, 32'h40, 32'hAAAA0001);
    drive(1, 1, 1'b1, 1'b1, 32'h44, 32'hBBBB0002);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_c_ack", 1, 32'(ack[1][0]), 1);
      chk("t6_d_ack", 1, 32'(ack[1][1]), 0);
      tick();
    end
    drive(1, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t6_d_ack_after", 1, 32'(ack[1][1]), 1);
    tick(); drive(1, 1, 1'b0, 1'b0, '0, '0);

    // Random traffic: unacked requests hold fields (occasionally withdraw),
    // acked or idle ports issue fresh random requests.
    repeat (3000) begin
      for (int p = 0; p < 2; p++) begin
        for (int q = 0; q < 2; q++) begin
          if (req[p][q] && !seen_ack[p][q]) begin
            if ($urandom_range(0, 15) == 0) req[p][q] = 1'b0;
          end else if ($urandom_range(0, 1) == 1) begin
            drive(p, q, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
          end else begin
            req[p][q] = 1'b0;
          end
        end
      end
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end

    rst = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int q = 0; q < 2; q++) req[p][q] = 1'b0;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
